// File: rtl/kul_mult_pkg.sv
// Shared helpers for the pipelined recursive Kulkarni multiplier.
// Cell width, mode encoding and pipeline-depth helpers.
package kul_mult_pkg;

    localparam int KUL_CELL_W = 4;

    typedef enum logic {
        KUL_EXACT  = 1'b0,
        KUL_APPROX = 1'b1
    } kul_mode_e;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r++;
        end
        return r;
    endfunction

    function automatic int lat(input int n);
        return clog2(n);
    endfunction

endpackage

// File: rtl/kul_cell2.sv
// 2x2 Kulkarni multiplier cell, combinational.
// Approximate mode maps 3*3 to 7 so the product fits in three bits.
module kul_cell2
    import kul_mult_pkg::*;
(
    input  logic [1:0]            i_a,
    input  logic [1:0]            i_b,
    input  kul_mode_e             i_mode,
    output logic [KUL_CELL_W-1:0] o_y
);

    // Select the exact 2-bit product or the Kulkarni approximation
    always_comb begin
        o_y = {2'b00, i_a} * {2'b00, i_b};
        if (i_mode == KUL_APPROX) begin
            o_y = {1'b0,
                   i_a[1] & i_b[1],
                   (i_a[1] & i_b[0]) | (i_a[0] & i_b[1]),
                   i_a[0] & i_b[0]};
        end
    end

endmodule

// File: rtl/kul_pipe_mult.sv
// Pipelined N x N recursive multiplier from 2x2 Kulkarni cells.
// Define KUL_ERR_STAT_EN to add an exact shadow path, out_err and err_cnt.
module kul_pipe_mult
    import kul_mult_pkg::*;
#(
    parameter int N     = 8,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic             in_approx,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   out_y,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int L  = lat(N);
    localparam int D0 = N / 2;

    logic             w_adv;
    logic [L-1:0]     r_vld;
    logic [TAG_W-1:0] r_tag [L];

    // Whole pipe moves unless a finished result is waiting downstream
    assign w_adv    = ~r_vld[L-1] | out_ready;
    assign in_ready = w_adv;

    // Valid and tag shift alongside the datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            for (int k = 0; k < L; k++) begin
                r_tag[k] <= '0;
            end
        end else if (w_adv) begin
            r_vld    <= {r_vld[L-2:0], in_valid};
            r_tag[0] <= in_tag;
            for (int k = 1; k < L; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    // Stage k holds a (N/2^(k+1))^2 grid of 2^(k+1)-bit sub-products
    for (genvar k = 0; k < L; k++) begin : g_stg
        localparam int W  = 2 ** (k + 1);
        localparam int D  = N / W;

        logic [2*W-1:0] r_p [D*D];
`ifdef KUL_ERR_STAT_EN
        logic [2*W-1:0] r_e [D*D];
`endif

        if (k == 0) begin : g_s0
            logic [KUL_CELL_W-1:0] w_c [D0*D0];
`ifdef KUL_ERR_STAT_EN
            logic [KUL_CELL_W-1:0] w_x [D0*D0];
`endif

            for (genvar i = 0; i < D0; i++) begin : g_i
                for (genvar j = 0; j < D0; j++) begin : g_j
                    kul_cell2 u_cell (
                        .i_a    (in_a[2*i +: 2]),
                        .i_b    (in_b[2*j +: 2]),
                        .i_mode (kul_mode_e'(in_approx)),
                        .o_y    (w_c[i*D0+j])
                    );
`ifdef KUL_ERR_STAT_EN
                    kul_cell2 u_xcell (
                        .i_a    (in_a[2*i +: 2]),
                        .i_b    (in_b[2*j +: 2]),
                        .i_mode (KUL_EXACT),
                        .o_y    (w_x[i*D0+j])
                    );
`endif
                end
            end

            // Register the raw cell products
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int n = 0; n < D0*D0; n++) begin
                        r_p[n] <= '0;
`ifdef KUL_ERR_STAT_EN
                        r_e[n] <= '0;
`endif
                    end
                end else if (w_adv) begin
                    r_p <= w_c;
`ifdef KUL_ERR_STAT_EN
                    r_e <= w_x;
`endif
                end
            end
        end else begin : g_sk
            localparam int H = W / 2;
            localparam int P = 2 * D;

            logic [2*W-1:0] w_s [D*D];
`ifdef KUL_ERR_STAT_EN
            logic [2*W-1:0] w_e [D*D];
`endif

            for (genvar i = 0; i < D; i++) begin : g_i
                for (genvar j = 0; j < D; j++) begin : g_j
                    assign w_s[i*D+j] =
                        (2*W)'(g_stg[k-1].r_p[(2*i)*P+2*j])
                      + ((2*W)'(g_stg[k-1].r_p[(2*i+1)*P+2*j]) << H)
                      + ((2*W)'(g_stg[k-1].r_p[(2*i)*P+2*j+1]) << H)
                      + ((2*W)'(g_stg[k-1].r_p[(2*i+1)*P+2*j+1]) << (2*H));
`ifdef KUL_ERR_STAT_EN
                    assign w_e[i*D+j] =
                        (2*W)'(g_stg[k-1].r_e[(2*i)*P+2*j])
                      + ((2*W)'(g_stg[k-1].r_e[(2*i+1)*P+2*j]) << H)
                      + ((2*W)'(g_stg[k-1].r_e[(2*i)*P+2*j+1]) << H)
                      + ((2*W)'(g_stg[k-1].r_e[(2*i+1)*P+2*j+1]) << (2*H));
`endif
                end
            end

            // Register the combined quad sums at full width
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int n = 0; n < D*D; n++) begin
                        r_p[n] <= '0;
`ifdef KUL_ERR_STAT_EN
                        r_e[n] <= '0;
`endif
                    end
                end else if (w_adv) begin
                    r_p <= w_s;
`ifdef KUL_ERR_STAT_EN
                    r_e <= w_e;
`endif
                end
            end
        end
    end

    assign out_valid = r_vld[L-1];
    assign out_y     = g_stg[L-1].r_p[0];
    assign out_tag   = r_tag[L-1];

`ifdef KUL_ERR_STAT_EN
    logic [2*N-1:0]   w_ye;
    logic [CNT_W-1:0] r_err_cnt;

    assign w_ye    = g_stg[L-1].r_e[0];
    assign out_err = r_vld[L-1] & (out_y != w_ye);
    assign err_cnt = r_err_cnt;

    // Count delivered erroneous results, sticking at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (out_valid & out_ready & out_err & ~&r_err_cnt) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end
`else
    assign out_err = 1'b0;
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_kul_pipe_mult.sv
// Self-checking bench for kul_pipe_mult (N=8, CNT_W=2).
// Digit-sum reference model plus directed literal vectors.
module tb_kul_pipe_mult;

`ifdef KUL_ERR_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        in_approx;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_y;
    logic [3:0]  out_tag;
    logic        out_err;
    logic [1:0]  err_cnt;

    typedef struct packed {
        logic [15:0] y;
        logic [3:0]  tag;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_acc = 0;
    int   n_out = 0;
    int   cyc   = 0;
    int   exp_cnt = 0;

    kul_pipe_mult #(.N(8), .TAG_W(4), .CNT_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_approx (in_approx),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_tag   (out_tag),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Product as a sum of base-4 digit products, 3*3 -> 7 when approximate
    function automatic logic [15:0] m_mult(input logic [7:0] a,
                                           input logic [7:0] b,
                                           input logic ap);
        int s;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                int da;
                int db;
                int c;
                da = (int'(a) >> (2*i)) & 3;
                db = (int'(b) >> (2*j)) & 3;
                c  = da * db;
                if (ap && c == 9) c = 7;
                s += c << (2*(i+j));
            end
        end
        return 16'(s);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    // Scoreboard: record accepted inputs, check every visible output
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            exp_cnt = 0;
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_out_y", 32'(out_y), 0);
            chk("rst_out_tag", 32'(out_tag), 0);
            chk("rst_out_err", 32'(out_err), 0);
            chk("rst_err_cnt", 32'(err_cnt), 0);
        end else begin
            chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
            chk("err_cnt", 32'(err_cnt), 32'(exp_cnt));
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 32'(out_valid), 0);
                end else begin
                    exp_t e;
                    e = q[0];
                    chk("out_y", 32'(out_y), 32'(e.y));
                    chk("out_tag", 32'(out_tag), 32'(e.tag));
                    chk("out_err", 32'(out_err), 32'(e.err));
                    if (out_ready) begin
                        void'(q.pop_front());
                        n_out++;
                        if (e.err && exp_cnt < 3) exp_cnt++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_t e;
                e.y   = m_mult(in_a, in_b, in_approx);
                e.tag = in_tag;
                e.err = STAT && (e.y != 16'(in_a) * 16'(in_b));
                q.push_back(e);
                n_acc++;
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        input logic ap, input logic [3:0] t);
        bit acc;
        int g;
        g = 0;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_approx = ap;
        in_tag    = t;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            g++;
        end while (!acc && g < 200);
        if (!acc) chk("send_timeout", 32'(acc), 1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (q.size() != 0 && g < 200) begin
            @(posedge clk);
            g++;
        end
        #1;
        chk("drain", 32'(q.size()), 0);
    endtask

    task automatic single(input logic [7:0] a, input logic [7:0] b,
                          input logic ap, input logic [3:0] t,
                          input logic [15:0] exp_y, input logic exp_err);
        int c;
        send(a, b, ap, t);
        idle();
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!out_valid && c < 20);
        chk("latency", 32'(c), 3);
        chk("y_literal", 32'(out_y), 32'(exp_y));
        chk("tag_literal", 32'(out_tag), 32'(t));
        chk("err_literal", 32'(out_err), 32'(exp_err));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int a0;
        int o0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_approx = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("model_ff_apx", 32'(m_mult(8'd255, 8'd255, 1'b1)), 32'hC58F);
        chk("model_ff_ex", 32'(m_mult(8'd255, 8'd255, 1'b0)), 32'hFE01);
        chk("model_23_apx", 32'(m_mult(8'd2, 8'd3, 1'b1)), 6);
        chk("model_33_apx", 32'(m_mult(8'd3, 8'd3, 1'b1)), 7);

        single(8'd255, 8'd255, 1'b1, 4'd1, 16'hC58F, STAT);
        single(8'd255, 8'd255, 1'b0, 4'd2, 16'hFE01, 1'b0);
        single(8'd2,   8'd3,   1'b1, 4'd3, 16'd6,    1'b0);
        single(8'd3,   8'd3,   1'b1, 4'd4, 16'd7,    STAT);
        single(8'd3,   8'd3,   1'b0, 4'd5, 16'd9,    1'b0);
        single(8'd0,   8'd200, 1'b1, 4'd6, 16'd0,    1'b0);

        t0 = cyc;
        for (int i = 0; i < 100; i++) begin
            send(8'($urandom), 8'($urandom), 1'($urandom), 4'(i));
        end
        chk("throughput_cycles", 32'(cyc - t0), 100);
        idle();
        drain();

        out_ready = 1'b0;
        a0 = n_acc;
        o0 = n_out;
        send(8'd17, 8'd33, 1'b1, 4'hA);
        send(8'd99, 8'd7,  1'b0, 4'hB);
        send(8'd15, 8'd15, 1'b1, 4'hC);
        in_valid = 1'b1;
        in_a     = 8'd200;
        in_b     = 8'd201;
        in_tag   = 4'hD;
        repeat (4) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 0);
        end
        chk("stall_accepted", 32'(n_acc - a0), 3);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(8'd200, 8'd201, 1'b1, 4'hD);
        send(8'd128, 8'd255, 1'b0, 4'hE);
        idle();
        drain();
        chk("stall_delivered", 32'(n_out - o0), 5);

        send(8'd10, 8'd20, 1'b1, 4'h1);
        send(8'd30, 8'd40, 1'b0, 4'h2);
        idle();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_valid", 32'(out_valid), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        o0 = n_out;
        repeat (6) @(negedge clk);
        chk("rst_no_stale", 32'(n_out - o0), 0);
        chk("rst_cnt_clear", 32'(err_cnt), 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            send(8'd3, 8'd3, 1'b1, 4'(i));
        end
        send(8'd3, 8'd3, 1'b0, 4'h9);
        idle();
        drain();
        @(negedge clk);
        chk("err_cnt_sat", 32'(err_cnt), STAT ? 3 : 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
